// File: rtl/scope_capture_buffer_pkg.sv
// -----------------------------------------------------------------------------
// scope_capture_buffer_pkg
// Shared definitions for the scope capture buffer slice.
//   - Default sample width, RAM address width and depth.
//   - One-hot state encoding for the capture/readout FSM.
// -----------------------------------------------------------------------------
package scope_capture_buffer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 9;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_CAPTURE = 5'b00010,
        ST_FROZEN  = 5'b00100,
        ST_READ    = 5'b01000,
        ST_RELEASE = 5'b10000
    } state_e;

endpackage

// File: rtl/scope_sample_ram.sv
// -----------------------------------------------------------------------------
// scope_sample_ram
// Simple dual-port sample RAM: synchronous write, synchronous read with one
// cycle of read latency. No reset so it maps onto block RAM.
// Ports:
//   clk        - clock
//   wr_en_i    - write enable
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_en_i    - read enable
//   rd_addr_i  - read address
//   rd_data_o  - read data, valid the cycle after rd_en_i
// -----------------------------------------------------------------------------
module scope_sample_ram
    import scope_capture_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/scope_capture_buffer.sv
// -----------------------------------------------------------------------------
// scope_capture_buffer
// Captures ADC samples into a circular RAM while the trigger FSM is busy,
// freezes the frame on done, streams it oldest-first over valid/ready and
// then pulses stop to re-arm the trigger FSM.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   i_busy         - capture one sample this cycle
//   i_done         - frame complete (level)
//   i_adc_data     - ADC sample
//   i_rd_start     - host request to read the frozen frame
//   o_frame_ready  - frame frozen, waiting for i_rd_start
//   o_rd_data      - stream data
//   o_rd_valid     - stream valid
//   i_rd_ready     - stream ready
//   o_rd_last      - final beat marker
//   o_stop         - one-cycle pulse, frame consumed
// -----------------------------------------------------------------------------
module scope_capture_buffer
    import scope_capture_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_busy,
    input  logic              i_done,
    input  logic [DATA_W-1:0] i_adc_data,
    input  logic              i_rd_start,
    output logic              o_frame_ready,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic              o_rd_last,
    output logic              o_stop
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q;
    logic [ADDR_W-1:0] wrPtr_q;
    logic [ADDR_W-1:0] rdPtr_q;
    logic [ADDR_W:0]   fill_q;
    logic [ADDR_W:0]   issueLeft_q;
    logic              frameReady_q;
    logic              stop_q;

    // Read pipeline: RAM output stage, output register and one skid entry.
    logic              ramVld_q;
    logic              ramLast_q;
    logic              outVld_q;
    logic              outLast_q;
    logic [DATA_W-1:0] outData_q;
    logic              skVld_q;
    logic              skLast_q;
    logic [DATA_W-1:0] skData_q;

    logic [DATA_W-1:0] ramRdata;
    logic              wrEn;
    logic              rdEn;
    logic              pop;
    logic              outLoad;
    logic [1:0]        occ;

    scope_sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wrEn),
        .wr_addr_i (wrPtr_q),
        .wr_data_i (i_adc_data),
        .rd_en_i   (rdEn),
        .rd_addr_i (rdPtr_q),
        .rd_data_o (ramRdata)
    );

    // A read is issued only when the output register plus skid can absorb
    // everything already held or in flight after this cycle's pop, so the
    // skid never overflows and a steady ready gives one beat per cycle.
    always_comb begin
        wrEn = 1'b0;
        if (state_q == ST_IDLE) begin
            wrEn = i_busy;
        end else if (state_q == ST_CAPTURE) begin
            wrEn = i_busy && !i_done;
        end
        pop     = outVld_q && i_rd_ready;
        outLoad = pop || !outVld_q;
        occ     = 2'(outVld_q) + 2'(skVld_q) + 2'(ramVld_q);
        rdEn    = (state_q == ST_READ) && (issueLeft_q != '0)
                  && ((occ - 2'(pop)) < 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            fill_q       <= '0;
            issueLeft_q  <= '0;
            frameReady_q <= 1'b0;
            stop_q       <= 1'b0;
            ramVld_q     <= 1'b0;
            ramLast_q    <= 1'b0;
            outVld_q     <= 1'b0;
            outLast_q    <= 1'b0;
            outData_q    <= '0;
            skVld_q      <= 1'b0;
            skLast_q     <= 1'b0;
            skData_q     <= '0;
        end else begin
            stop_q    <= 1'b0;
            ramVld_q  <= rdEn;
            ramLast_q <= rdEn && (issueLeft_q == ONE_C);

            if (rdEn) begin
                rdPtr_q     <= rdPtr_q + 1'b1;
                issueLeft_q <= issueLeft_q - ONE_C;
            end

            // Output register refills from the skid first to keep order.
            if (outLoad) begin
                if (skVld_q) begin
                    outVld_q  <= 1'b1;
                    outData_q <= skData_q;
                    outLast_q <= skLast_q;
                    skVld_q   <= ramVld_q;
                    if (ramVld_q) begin
                        skData_q <= ramRdata;
                        skLast_q <= ramLast_q;
                    end
                end else begin
                    outVld_q <= ramVld_q;
                    if (ramVld_q) begin
                        outData_q <= ramRdata;
                        outLast_q <= ramLast_q;
                    end
                end
            end else if (ramVld_q) begin
                skVld_q  <= 1'b1;
                skData_q <= ramRdata;
                skLast_q <= ramLast_q;
            end

            if (wrEn) begin
                wrPtr_q <= wrPtr_q + 1'b1;
                if (fill_q != DEPTH_C) begin
                    fill_q <= fill_q + ONE_C;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (i_busy) begin
                        state_q <= ST_CAPTURE;
                    end else if (i_done) begin
                        // Done with nothing captured: freeze an empty frame.
                        state_q      <= ST_FROZEN;
                        frameReady_q <= 1'b1;
                        rdPtr_q      <= '0;
                        issueLeft_q  <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (i_done) begin
                        state_q      <= ST_FROZEN;
                        frameReady_q <= 1'b1;
                        // A wrapped buffer's oldest sample sits at wrPtr.
                        rdPtr_q      <= (fill_q == DEPTH_C) ? wrPtr_q : '0;
                        issueLeft_q  <= fill_q;
                    end
                end
                ST_FROZEN: begin
                    if (i_rd_start) begin
                        frameReady_q <= 1'b0;
                        if (fill_q == '0) begin
                            state_q <= ST_RELEASE;
                            stop_q  <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (pop && outLast_q) begin
                        state_q <= ST_RELEASE;
                        stop_q  <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                    wrPtr_q <= '0;
                    fill_q  <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_frame_ready = frameReady_q;
    assign o_rd_data     = outData_q;
    assign o_rd_valid    = outVld_q;
    assign o_rd_last     = outLast_q;
    assign o_stop        = stop_q;

endmodule

// File: doc/scope_capture_buffer.md
Name: scope_capture_buffer

Overview:
Downstream of the scope trigger FSM. Writes every ADC sample into a circular sample RAM while the FSM reports busy, and freezes the frame when the FSM reports done. It then streams the frame oldest-first over a valid/ready interface to the host link. After the last beat it pulses stop back to the FSM to re-arm it.

Parameters:
DATA_W, 8, ADC sample width
ADDR_W, 9, RAM address width; DEPTH = 2**ADDR_W = 512 samples (PREV_MAX + POST_MAX)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous and active-low
i_busy  in  1  FSM busy; each cycle high = one sample to capture
i_done  in  1  FSM done level; frame complete
i_adc_data  in  DATA_W  ADC sample, same timing as i_busy
i_rd_start  in  1  host request to read the frozen frame
o_frame_ready  out  1  frame frozen and waiting for i_rd_start
o_rd_data  out  DATA_W  stream data
o_rd_valid  out  1  stream valid
i_rd_ready  in  1  stream ready
o_rd_last  out  1  high with the final beat
o_stop  out  1  one-cycle pulse to FSM i_stop; frame consumed

Behaviour:
- Reset (rst_n=0, async): state IDLE; wr_ptr=0, fill=0; all outputs 0. RAM contents are not cleared and are don't-care.
- States: IDLE, CAPTURE, FROZEN, READ, RELEASE.
- IDLE:
  - i_busy=1 -> CAPTURE. This first busy cycle is written to addr 0; wr_ptr becomes 1 and fill becomes 1.
- CAPTURE:
  - Each cycle with i_busy=1: RAM[wr_ptr] <= i_adc_data; wr_ptr+1 wraps mod DEPTH; fill+1 saturates at DEPTH (fill is ADDR_W+1 bits).
  - i_busy=0 with i_done=0 is a pause: no write, stay in CAPTURE.
  - i_done=1 -> FROZEN. No write that cycle, even if i_busy=1.
- FROZEN:
  - rd_ptr = (fill==DEPTH) ? wr_ptr : 0; remaining = fill.
  - o_frame_ready=1. i_rd_start=1 -> READ with o_frame_ready cleared.
  - If fill==0, i_rd_start goes to RELEASE instead.
- READ:
  - RAM read is synchronous (1-cycle latency). Output skid/prefetch register required.
  - o_rd_valid first rises no later than 2 cycles after i_rd_start is sampled.
  - With i_rd_ready held high: one beat per cycle, no bubbles.
  - o_rd_data and o_rd_last are stable while o_rd_valid && !i_rd_ready. Valid never drops without a handshake.
  - rd_ptr wraps mod DEPTH. Exactly `fill` beats are emitted; o_rd_last is high on beat `fill`.
  - Last handshake -> RELEASE.
- RELEASE: o_stop=1 for exactly one cycle, then IDLE with wr_ptr=0 and fill=0.
- Ignored inputs:
  - i_rd_start outside FROZEN.
  - i_busy outside IDLE/CAPTURE.
  - i_done outside CAPTURE.
- Reset mid-capture or mid-read aborts immediately. No o_stop is emitted, and the frame is lost.

Decomposition:
- Shared package holds:
  - state encoding constants (one-hot, matching FSM style)
  - DEPTH / ADDR_W / DATA_W defaults
- One sub-module: scope_sample_ram, a simple dual-port RAM with sync write, sync read, and 1-cycle read latency, inferable as BSRAM.
- Pointers, FSM and skid register stay in the top.

Test Plan:
1. Wrap: i_busy high 600 cycles with data = cycle index & 0xFF, then i_done; i_rd_start with ready=1 -> 512 beats. First = 88, last = 87 (599&0xFF) with o_rd_last. Then o_stop for 1 cycle.
2. Partial: i_busy 100 cycles (data 0..99), done, read -> exactly 100 beats 0..99. First valid ≤2 cycles after i_rd_start; beat 100 has o_rd_last.
3. Backpressure: repeat test 2 with i_rd_ready toggling pseudo-randomly -> same 100-value sequence; data/last held stable across every stall; no duplicates or drops.
4. Empty frame: i_done without any busy cycle, then i_rd_start -> o_rd_valid never rises; o_stop pulses 1 cycle; back to IDLE.
5. Pause: i_busy high 10, low 5 (data changing), high 10, done -> 20 beats. Paused-cycle data is absent.
6. Reset mid-read: rst_n low during beat 50 of test 2 -> all outputs 0 asynchronously, no o_stop. A new 30-sample capture afterwards reads back 30 correct beats.
